// File: rtl/q2fsm_pkg.sv
// -----------------------------------------------------------------------------
// q2fsm_pkg
// Shared definitions for the time-shared w-sequence detector.
//   state_e     : 3-bit detector state (A..F). Codes 6 and 7 are illegal.
//   next_state  : one detector step, given the current code and input bit w.
//                 Illegal codes recover to A.
//   z_of        : detector output. High in E or F.
// -----------------------------------------------------------------------------
package q2fsm_pkg;

    typedef enum logic [2:0] {
        ST_A = 3'd0,
        ST_B = 3'd1,
        ST_C = 3'd2,
        ST_D = 3'd3,
        ST_E = 3'd4,
        ST_F = 3'd5
    } state_e;

    // Raw 3-bit input so that illegal codes (6, 7) can be recovered.
    function automatic logic [2:0] next_state(input logic [2:0] s, input logic w);
        logic [2:0] n;
        case (s)
            ST_A:    n = w ? ST_B : ST_A;
            ST_B:    n = w ? ST_C : ST_D;
            ST_C:    n = w ? ST_E : ST_D;
            ST_D:    n = w ? ST_F : ST_A;
            ST_E:    n = w ? ST_E : ST_D;
            ST_F:    n = w ? ST_C : ST_D;
            default: n = ST_A;
        endcase
        return n;
    endfunction

    function automatic logic z_of(input logic [2:0] s);
        return (s == ST_E) || (s == ST_F);
    endfunction

endpackage

// File: rtl/q2fsm_ctx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter.
//   req : N request lines
//   ptr : index of the most recently granted requester
//   gnt : one-hot grant (or zero). The search starts at ptr+1 and wraps
//         modulo N, so the last winner has the lowest priority.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    int   w_idx;
    logic w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/q2fsm_ctx_scheduler.sv
// -----------------------------------------------------------------------------
// q2fsm_ctx_scheduler
// Time-shares one w-sequence detector among NUM_CH serial bit streams. Each
// channel keeps a 3-bit state context. Each cycle one eligible channel is
// granted round-robin, its context is advanced by its input bit, and the
// post-update state and z are presented on a registered valid/ready output.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   in_valid   : [NUM_CH] channel i presents a bit
//   in_w       : [NUM_CH] bit value for channel i
//   in_ready   : [NUM_CH] one-hot grant (combinational)
//   ch_clr     : [NUM_CH] synchronous clear of channel i context to A
//   out_valid  : result available
//   out_ready  : downstream accepts result
//   out_ch     : [CH_W] channel the result belongs to
//   out_z      : detector output after the consumed bit
//   out_state  : [3] post-update state code (debug view of the detector)
//
// Handshake: an input bit transfers on a rising edge where in_valid[i] and
// in_ready[i] are both high. A result transfers on a rising edge where
// out_valid and out_ready are both high. A source does not need to wait for
// in_ready before raising in_valid. out_valid, once raised, stays high with
// out_ch/out_z/out_state stable until the transfer happens.
// -----------------------------------------------------------------------------
module q2fsm_ctx_scheduler
    import q2fsm_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH-1:0]          in_w,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [NUM_CH-1:0]          ch_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic                       out_z,
    output logic [2:0]                 out_state
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [2:0]        r_ctx [NUM_CH];
    logic [CH_W-1:0]   r_last;
    logic              r_out_valid;
    logic [CH_W-1:0]   r_out_ch;
    logic              r_out_z;
    logic [2:0]        r_out_state;

    logic              w_stall;
    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_gnt;
    logic              w_any_gnt;
    logic [CH_W-1:0]   w_gnt_idx;
    logic [2:0]        w_next;

    // A pending result that the downstream has not taken blocks all grants.
    assign w_stall = r_out_valid && !out_ready;

    // Clear wins over consume: a channel being cleared is not eligible.
    // in_w is deliberately absent from this path.
    assign w_req = in_valid & ~ch_clr & {NUM_CH{!w_stall}};

    rr_arbiter #(
        .N  (NUM_CH),
        .PW (CH_W)
    ) u_arb (
        .req (w_req),
        .ptr (r_last),
        .gnt (w_gnt)
    );

    assign in_ready  = w_gnt;
    assign w_any_gnt = |w_gnt;

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt[i]) w_gnt_idx = CH_W'(i);
        end
    end

    assign w_next = next_state(r_ctx[w_gnt_idx], in_w[w_gnt_idx]);

    // Per-channel contexts. A grant and a clear never hit the same channel
    // in one cycle because cleared channels are masked from arbitration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) r_ctx[i] <= ST_A;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clr[i])                      r_ctx[i] <= ST_A;
                else if (w_gnt[i])                  r_ctx[i] <= w_next;
            end
        end
    end

    // Output register and round-robin pointer. The pointer resets to the
    // last channel so that channel 0 has first priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_z     <= 1'b0;
            r_out_state <= 3'd0;
            r_last      <= CH_W'(NUM_CH - 1);
        end else if (!w_stall) begin
            if (w_any_gnt) begin
                r_out_valid <= 1'b1;
                r_out_ch    <= w_gnt_idx;
                r_out_state <= w_next;
                r_out_z     <= z_of(w_next);
                r_last      <= w_gnt_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_z     = r_out_z;
    assign out_state = r_out_state;

endmodule

// File: tb/tb_q2fsm_ctx_scheduler.sv
module tb_q2fsm_ctx_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  // ---------------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0] in_valid = '0;
  logic [NUM_CH-1:0] in_w = '0;
  logic [NUM_CH-1:0] in_ready;
  logic [NUM_CH-1:0] ch_clr = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CH_W-1:0]   out_ch;
  logic              out_z;
  logic [2:0]        out_state;

  q2fsm_ctx_scheduler #(.NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_w      (in_w),
    .in_ready  (in_ready),
    .ch_clr    (ch_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_z     (out_z),
    .out_state (out_state)
  );

  // ---------------------------------------------------------------------------
  // scoreboard and reference model
  // ---------------------------------------------------------------------------
  logic [5:0] exp_q[$];   // {ch[1:0], state[2:0], z}
  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] m_ctx [NUM_CH];
  int         m_last;
  logic       m_ov;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Detector transition table: rows A..F, columns w=0 / w=1.
  function automatic logic [2:0] model_next(input logic [2:0] s, input logic w);
    case (s)
      3'd0: return w ? 3'd1 : 3'd0;
      3'd1: return w ? 3'd2 : 3'd3;
      3'd2: return w ? 3'd4 : 3'd3;
      3'd3: return w ? 3'd5 : 3'd0;
      3'd4: return w ? 3'd4 : 3'd3;
      3'd5: return w ? 3'd2 : 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_ctx[i] = 3'd0;
    m_last = NUM_CH - 1;
    m_ov   = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle with the inputs currently driven. Checks the registered
  // output against the scoreboard, checks the grant against the model, then
  // advances the model the way the edge will advance the DUT.
  task automatic step();
    logic              stall;
    logic [NUM_CH-1:0] exp_gnt;
    logic [2:0]        nxt;
    logic [5:0]        e;
    int                g;
    int                idx;
    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    if (out_valid) begin
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("out_ch", out_ch, e[5:4]);
        check("out_state", out_state, e[3:1]);
        check("out_z", out_z, e[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    stall   = m_ov && !out_ready;
    exp_gnt = '0;
    g       = -1;
    if (!stall) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = (m_last + k) % NUM_CH;
        if (g < 0 && in_valid[idx] && !ch_clr[idx]) g = idx;
      end
    end
    if (g >= 0) exp_gnt[g] = 1'b1;
    check("in_ready", in_ready, exp_gnt);
    if (g >= 0) begin
      nxt = model_next(m_ctx[g], in_w[g]);
      m_ctx[g] = nxt;
      exp_q.push_back({2'(g), nxt, (nxt == 3'd4) || (nxt == 3'd5)});
      m_last = g;
    end
    for (int i = 0; i < NUM_CH; i++) if (ch_clr[i]) m_ctx[i] = 3'd0;
    m_ov = stall ? 1'b1 : (g >= 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] w,
                       input logic [NUM_CH-1:0] clr, input logic rdy);
    in_valid  = v;
    in_w      = w;
    ch_clr    = clr;
    out_ready = rdy;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] seq1 = 4'b1111;   // ch0: 1,1,1,1
  logic [4:0]        seq2 = 5'b01101;  // ch1: bit0 first -> 1,0,1,1,0

  initial begin
    model_reset();
    #23;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_z", out_z, 0);
    check("rst_out_state", out_state, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // ch0: w=1,1,1,1 -> B,C,E,E
    for (int i = 0; i < 4; i++) drive(4'b0001, {3'b000, seq1[i]}, '0, 1'b1);
    idle(1);
    check("t1_ctx0_is_E", dut.r_ctx[0], 3'd4);

    // ch1: w=1,0,1,1,0 -> B,D,F,C,D
    for (int i = 0; i < 5; i++) drive(4'b0010, {2'b00, seq2[i], 1'b0}, '0, 1'b1);
    idle(1);

    // clear everything, then all channels stream w=1 for two rounds
    drive('0, '0, 4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) drive(4'b1111, 4'b1111, '0, 1'b1);
    idle(1);

    // stall for 3 cycles with all channels requesting, then release
    drive(4'b1111, 4'b0101, '0, 1'b1);
    for (int i = 0; i < 3; i++) drive(4'b1111, 4'b0101, '0, 1'b0);
    for (int i = 0; i < 4; i++) drive(4'b1111, 4'b0101, '0, 1'b1);
    idle(1);

    // ch2 to E, then clear together with a request, then consume w=1 -> B
    drive('0, '0, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) drive(4'b0100, 4'b0100, '0, 1'b1);
    drive(4'b0100, 4'b0100, 4'b0100, 1'b1);
    drive(4'b0100, 4'b0100, '0, 1'b1);
    idle(1);

    // random traffic with random backpressure and occasional clears
    for (int i = 0; i < 60; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
            1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) drive('0, '0, '0, 1'b1);

    // async reset mid-stream with a pending result
    drive(4'b0010, 4'b0010, '0, 1'b0);
    in_valid = '0;
    #2;
    check("pre_rst_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_state", out_state, 0);
    model_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    // all channels request: ch0 must win first, and its context is back at A
    drive(4'b1111, 4'b1111, '0, 1'b1);
    idle(2);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
